// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: registered, multi-cycle instruction sequencer that sits between IF/ID and EX.
// Each accepted LC-3b/LC-3X instruction is expanded into one or more micro-ops.
// LDI/STI issue an address-fetch micro-op followed by a final-phase micro-op.
// MUL/DIV keep the sequencer busy for a parametrised number of EX cycles.
// The module uses a valid/ready handshake on both sides, with stall and flush.

`timescale 1ns/1ps

module ctrl_sequencer #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [11:0] in_ir,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_opcode,
    output logic [3:0]  out_aluop,
    output logic        out_load_rf,
    output logic        out_load_cc,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic [1:0]  out_byte_en,
    output logic        out_ind_ph,
    output logic        out_is_nop,
    output logic        busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    // The busy counter is loaded with LAT-1, so a latency of 1 loads zero.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    // LC-3b opcode map (IR[15:12])
    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_STB  = 4'h3;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_SHF  = 4'hD;
    localparam logic [3:0] OP_LEA  = 4'hE;
    localparam logic [3:0] OP_TRAP = 4'hF;

    // lc3b_aluop encoding
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_AND  = 4'd1;
    localparam logic [3:0] ALU_NOT  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_NAND = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIV  = 4'd11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_IND    = 2'd1,
        ST_MDWAIT = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ind_is_sti;

    logic [3:0]       dec_aluop;
    logic             dec_load_rf;
    logic             dec_load_cc;
    logic             dec_mem_rd;
    logic             dec_mem_wr;
    logic [1:0]       dec_byte_en;
    logic             dec_is_nop;
    logic             dec_ind;
    logic             dec_md;
    logic [CNT_W-1:0] dec_cnt;
    logic             accept;
    logic [1:0]       lc3x;
    logic             unused_ir;

    // Register fields that only EX looks at; the sequencer does not need them.
    assign unused_ir = ^{in_ir[8:6], in_ir[3:1]};

    assign lc3x     = in_ir[5:4];
    assign in_ready = (state == ST_RUN) & ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign busy     = (state != ST_RUN);

    // Decode the presented instruction into its first micro-op and its sequencing needs.
    // LC-3X repurposes IR[5:4] of ADD/AND, so that field alone selects the ALU operation.
    always_comb begin
        dec_aluop   = ALU_ADD;
        dec_load_rf = 1'b0;
        dec_load_cc = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_byte_en = 2'b11;
        dec_is_nop  = 1'b0;
        dec_ind     = 1'b0;
        dec_md      = 1'b0;
        dec_cnt     = '0;
        unique case (in_opcode)
            OP_ADD: begin
                dec_load_rf = 1'b1;
                dec_load_cc = 1'b1;
                unique case (lc3x)
                    2'b00: dec_aluop = ALU_ADD;
                    2'b01: begin
                        dec_aluop = ALU_DIV;
                        dec_md    = 1'b1;
                        dec_cnt   = DIV_CNT;
                    end
                    2'b10: begin
                        dec_aluop = ALU_MUL;
                        dec_md    = 1'b1;
                        dec_cnt   = MUL_CNT;
                    end
                    default: dec_aluop = ALU_SUB;
                endcase
            end
            OP_AND: begin
                dec_load_rf = 1'b1;
                dec_load_cc = 1'b1;
                unique case (lc3x)
                    2'b00:   dec_aluop = ALU_AND;
                    2'b01:   dec_aluop = ALU_OR;
                    2'b10:   dec_aluop = ALU_XOR;
                    default: dec_aluop = ALU_NAND;
                endcase
            end
            OP_NOT: begin
                dec_aluop   = ALU_NOT;
                dec_load_rf = 1'b1;
                dec_load_cc = 1'b1;
            end
            OP_SHF: begin
                dec_load_rf = 1'b1;
                dec_load_cc = 1'b1;
                if (!in_ir[4])
                    dec_aluop = ALU_SLL;
                else if (!in_ir[5])
                    dec_aluop = ALU_SRL;
                else
                    dec_aluop = ALU_SRA;
            end
            OP_LDR: begin
                dec_mem_rd  = 1'b1;
                dec_load_rf = 1'b1;
                dec_load_cc = 1'b1;
            end
            OP_STR: dec_mem_wr = 1'b1;
            OP_LDB: begin
                dec_mem_rd  = 1'b1;
                dec_load_rf = 1'b1;
                dec_load_cc = 1'b1;
                dec_byte_en = in_ir[0] ? 2'b10 : 2'b01;
            end
            OP_STB: begin
                dec_mem_wr  = 1'b1;
                dec_byte_en = in_ir[0] ? 2'b10 : 2'b01;
            end
            OP_LEA:  dec_load_rf = 1'b1;
            OP_JSR:  dec_load_rf = 1'b1;
            OP_JMP:  dec_load_rf = 1'b0;
            OP_TRAP: begin
                dec_mem_rd  = 1'b1;
                dec_load_rf = 1'b1;
            end
            OP_LDI, OP_STI: begin
                dec_mem_rd = 1'b1;
                dec_ind    = 1'b1;
            end
            OP_BR: dec_is_nop = (in_ir[11:9] == 3'b000);
            default: dec_is_nop = 1'b1;
        endcase
    end

    // Sequencer FSM and micro-op register: flush wins, then accept, hold or phase advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RUN;
            cnt         <= '0;
            ind_is_sti  <= 1'b0;
            out_valid   <= 1'b0;
            out_opcode  <= 4'h0;
            out_aluop   <= 4'h0;
            out_load_rf <= 1'b0;
            out_load_cc <= 1'b0;
            out_mem_rd  <= 1'b0;
            out_mem_wr  <= 1'b0;
            out_byte_en <= 2'b11;
            out_ind_ph  <= 1'b0;
            out_is_nop  <= 1'b0;
        end else if (flush) begin
            state     <= ST_RUN;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (accept) begin
                        out_valid   <= 1'b1;
                        out_opcode  <= in_opcode;
                        out_aluop   <= dec_aluop;
                        out_load_rf <= dec_load_rf;
                        out_load_cc <= dec_load_cc;
                        out_mem_rd  <= dec_mem_rd;
                        out_mem_wr  <= dec_mem_wr;
                        out_byte_en <= dec_byte_en;
                        out_ind_ph  <= 1'b0;
                        out_is_nop  <= dec_is_nop;
                        if (dec_ind) begin
                            state      <= ST_IND;
                            ind_is_sti <= (in_opcode == OP_STI);
                        end else if (dec_md && (dec_cnt != '0)) begin
                            state <= ST_MDWAIT;
                            cnt   <= dec_cnt;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_IND: begin
                    if (!out_valid) begin
                        state <= ST_RUN;
                    end else if (out_ready) begin
                        out_ind_ph  <= 1'b1;
                        out_mem_rd  <= ~ind_is_sti;
                        out_mem_wr  <= ind_is_sti;
                        out_load_rf <= ~ind_is_sti;
                        out_load_cc <= ~ind_is_sti;
                        state       <= ST_RUN;
                    end
                end
                ST_MDWAIT: begin
                    if (!out_valid || out_ready) begin
                        out_valid <= 1'b0;
                        if (cnt == '0)
                            state <= ST_RUN;
                        else
                            cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed bench for ctrl_sequencer with hand-computed expectations.
// Inputs change on the falling edge; registered outputs are sampled on the next falling edge.

`timescale 1ns/1ps

module tb_ctrl_sequencer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [11:0] in_ir;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [3:0]  out_aluop;
    logic        out_load_rf;
    logic        out_load_cc;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic [1:0]  out_byte_en;
    logic        out_ind_ph;
    logic        out_is_nop;
    logic        busy;

    int checks;
    int errors;

    ctrl_sequencer #(.MUL_LAT(4), .DIV_LAT(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_ir       (in_ir),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_aluop   (out_aluop),
        .out_load_rf (out_load_rf),
        .out_load_cc (out_load_cc),
        .out_mem_rd  (out_mem_rd),
        .out_mem_wr  (out_mem_wr),
        .out_byte_en (out_byte_en),
        .out_ind_ph  (out_ind_ph),
        .out_is_nop  (out_is_nop),
        .busy        (busy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [11:0] ir,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_opcode = op;
        in_ir     = ir;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        assert (actual === expected) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Directed scenario sequence
    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        applyStimulus(1'b0, 4'h0, 12'h000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_valid",    32'(out_valid),   32'd0);
        checkOutput("rst_byte_en",  32'(out_byte_en), 32'd3);
        checkOutput("rst_busy",     32'(busy),        32'd0);
        checkOutput("rst_load_rf",  32'(out_load_rf), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready),    32'd1);
        reset_n = 1'b1;

        // ADD R1,R2,R3
        applyStimulus(1'b1, 4'h1, 12'h283, 1'b1, 1'b0);
        #1 checkOutput("add_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        checkOutput("add_valid",   32'(out_valid),   32'd1);
        checkOutput("add_aluop",   32'(out_aluop),   32'd0);
        checkOutput("add_load_rf", 32'(out_load_rf), 32'd1);
        checkOutput("add_load_cc", 32'(out_load_cc), 32'd1);
        checkOutput("add_mem_rd",  32'(out_mem_rd),  32'd0);

        // Back-to-back AND then NAND
        applyStimulus(1'b1, 4'h5, 12'h000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("and_aluop",  32'(out_aluop),  32'd1);
        checkOutput("and_opcode", 32'(out_opcode), 32'd5);
        applyStimulus(1'b1, 4'h5, 12'h030, 1'b1, 1'b0);
        #1 checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        checkOutput("nand_aluop", 32'(out_aluop), 32'd6);

        // Stall: SUB presented while EX is not ready
        applyStimulus(1'b1, 4'h1, 12'h030, 1'b0, 1'b0);
        #1 checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("stall_aluop",  32'(out_aluop),  32'd6);
        checkOutput("stall_valid",  32'(out_valid),  32'd1);
        checkOutput("stall_opcode", 32'(out_opcode), 32'd5);
        applyStimulus(1'b1, 4'h1, 12'h030, 1'b1, 1'b0);
        #1 checkOutput("unstall_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        checkOutput("sub_aluop",  32'(out_aluop),  32'd3);
        checkOutput("sub_opcode", 32'(out_opcode), 32'd1);

        // OR via AND lc3x=01, then drain
        applyStimulus(1'b1, 4'h5, 12'h010, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("or_aluop", 32'(out_aluop), 32'd4);
        applyStimulus(1'b0, 4'h0, 12'h000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("drain_valid", 32'(out_valid), 32'd0);

        // Shifts
        applyStimulus(1'b1, 4'hD, 12'h030, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("sra_aluop", 32'(out_aluop), 32'd9);
        applyStimulus(1'b1, 4'hD, 12'h000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("sll_aluop", 32'(out_aluop), 32'd7);
        applyStimulus(1'b1, 4'hD, 12'h010, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("srl_aluop", 32'(out_aluop), 32'd8);

        // Byte loads and stores
        applyStimulus(1'b1, 4'h2, 12'h001, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("ldb_byte_en", 32'(out_byte_en), 32'd2);
        checkOutput("ldb_mem_rd",  32'(out_mem_rd),  32'd1);
        checkOutput("ldb_load_rf", 32'(out_load_rf), 32'd1);
        applyStimulus(1'b1, 4'h3, 12'h000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("stb_byte_en", 32'(out_byte_en), 32'd1);
        checkOutput("stb_mem_wr",  32'(out_mem_wr),  32'd1);
        checkOutput("stb_load_rf", 32'(out_load_rf), 32'd0);

        // Bubbles: BR never and RTI; BR nzp is a real micro-op
        applyStimulus(1'b1, 4'h0, 12'h000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("brnv_nop",     32'(out_is_nop),  32'd1);
        checkOutput("brnv_load_cc", 32'(out_load_cc), 32'd0);
        checkOutput("brnv_valid",   32'(out_valid),   32'd1);
        applyStimulus(1'b1, 4'h0, 12'hE00, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("br_nzp_nop", 32'(out_is_nop), 32'd0);
        applyStimulus(1'b1, 4'h8, 12'h000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rti_nop",     32'(out_is_nop),  32'd1);
        checkOutput("rti_load_rf", 32'(out_load_rf), 32'd0);
        applyStimulus(1'b1, 4'h9, 12'h03F, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("not_aluop", 32'(out_aluop),  32'd2);
        checkOutput("not_nop",   32'(out_is_nop), 32'd0);
        applyStimulus(1'b0, 4'h0, 12'h000, 1'b1, 1'b0);
        @(negedge clk);

        // LDI: two micro-ops, nothing accepted in between
        applyStimulus(1'b1, 4'hA, 12'h200, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("ldi0_valid",   32'(out_valid),   32'd1);
        checkOutput("ldi0_ind_ph",  32'(out_ind_ph),  32'd0);
        checkOutput("ldi0_mem_rd",  32'(out_mem_rd),  32'd1);
        checkOutput("ldi0_load_rf", 32'(out_load_rf), 32'd0);
        checkOutput("ldi0_busy",    32'(busy),        32'd1);
        applyStimulus(1'b1, 4'h1, 12'h283, 1'b1, 1'b0);
        #1 checkOutput("ldi_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("ldi1_valid",   32'(out_valid),   32'd1);
        checkOutput("ldi1_ind_ph",  32'(out_ind_ph),  32'd1);
        checkOutput("ldi1_mem_rd",  32'(out_mem_rd),  32'd1);
        checkOutput("ldi1_load_rf", 32'(out_load_rf), 32'd1);
        checkOutput("ldi1_load_cc", 32'(out_load_cc), 32'd1);
        checkOutput("ldi1_opcode",  32'(out_opcode),  32'hA);
        checkOutput("ldi1_busy",    32'(busy),        32'd0);
        applyStimulus(1'b0, 4'h0, 12'h000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("ldi_drain_valid", 32'(out_valid), 32'd0);

        // STI with a stall on the address phase
        applyStimulus(1'b1, 4'hB, 12'h200, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 4'h0, 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("sti0_ind_ph", 32'(out_ind_ph), 32'd0);
        checkOutput("sti0_mem_rd", 32'(out_mem_rd), 32'd1);
        checkOutput("sti0_mem_wr", 32'(out_mem_wr), 32'd0);
        applyStimulus(1'b0, 4'h0, 12'h000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("sti1_ind_ph",  32'(out_ind_ph),  32'd1);
        checkOutput("sti1_mem_wr",  32'(out_mem_wr),  32'd1);
        checkOutput("sti1_mem_rd",  32'(out_mem_rd),  32'd0);
        checkOutput("sti1_load_rf", 32'(out_load_rf), 32'd0);
        @(negedge clk);

        // MUL holds the sequencer for 3 cycles after its micro-op is consumed
        applyStimulus(1'b1, 4'h1, 12'h020, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("mul_aluop", 32'(out_aluop), 32'd10);
        checkOutput("mul_busy",  32'(busy),      32'd1);
        applyStimulus(1'b1, 4'h1, 12'h283, 1'b1, 1'b0);
        #1 checkOutput("mul_c1_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("mul_consumed_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("mul_wait_in_ready", 32'(in_ready), 32'd0);
            checkOutput("mul_wait_busy",     32'(busy),     32'd1);
            @(negedge clk);
        end
        checkOutput("mul_done_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mul_done_busy",     32'(busy),     32'd0);
        @(negedge clk);
        checkOutput("mul_next_valid", 32'(out_valid), 32'd1);
        checkOutput("mul_next_aluop", 32'(out_aluop), 32'd0);
        applyStimulus(1'b0, 4'h0, 12'h000, 1'b1, 1'b0);
        @(negedge clk);

        // DIV flushed while its counter sits at 10
        applyStimulus(1'b1, 4'h1, 12'h010, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("div_aluop", 32'(out_aluop), 32'd11);
        applyStimulus(1'b0, 4'h0, 12'h000, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("div_wait_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 4'h1, 12'h283, 1'b1, 1'b1);
        #1 checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("flush_busy",  32'(busy),      32'd0);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 4'h1, 12'h283, 1'b1, 1'b0);
        #1 checkOutput("post_flush_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        checkOutput("post_flush_valid", 32'(out_valid), 32'd1);
        checkOutput("post_flush_aluop", 32'(out_aluop), 32'd0);

        // Flush with a valid instruction in RUN drops it
        applyStimulus(1'b1, 4'h5, 12'h000, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("run_flush_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset while LDI is in its address phase
        applyStimulus(1'b1, 4'hA, 12'h200, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 4'h0, 12'h000, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_valid",    32'(out_valid),   32'd0);
        checkOutput("arst_busy",     32'(busy),        32'd0);
        checkOutput("arst_mem_rd",   32'(out_mem_rd),  32'd0);
        checkOutput("arst_byte_en",  32'(out_byte_en), 32'd3);
        checkOutput("arst_in_ready", 32'(in_ready),    32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b1, 4'h9, 12'h03F, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("post_rst_valid",   32'(out_valid),   32'd1);
        checkOutput("post_rst_aluop",   32'(out_aluop),   32'd2);
        checkOutput("post_rst_ind_ph",  32'(out_ind_ph),  32'd0);
        checkOutput("post_rst_load_rf", 32'(out_load_rf), 32'd1);
        checkOutput("post_rst_busy",    32'(busy),        32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
